xor_descrambler: RTL and testbench
==================================

# xor_descrambler

Byte-stream additive descrambler: it XORs each accepted input beat with the keystream of a 7-bit LFSR (x^7 + x^4 + 1, the 802.11 polynomial) and emits the result one cycle later through a registered valid/ready output. It is the receive-side counterpart of the XOR scrambler path. Because an additive scrambler is self-inverse, scrambled data fed through this block with the same seed and sync alignment comes back as the original data. It sits between the serial/link input stage and downstream byte consumers.

## Interface
- `DATA_W`, default 8: beat width in bits; keystream bits are applied LSB first.
- `SEED`, default 7'h7F: LFSR load value on `sync`. A value of 0 is illegal; the block loads 7'h7F instead.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `sync` input, 1 bit: single-cycle pulse that reloads the LFSR with `SEED` and enters RUN.
- `in_data` input, `DATA_W` bits: scrambled beat.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: block can accept a beat.
- `out_data` output, `DATA_W` bits: descrambled beat, registered.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: downstream accepts the beat.
- `beat_cnt` output, 16 bits: beats accepted since the last `sync`; wraps modulo 2^16.

## Operation
- States:
  - WAIT_SYNC is entered on reset. `in_ready` = 0 and no beat is accepted.
  - RUN is entered on any `sync`. In RUN, `in_ready` = !`out_valid` || `out_ready`.
- Transitions: WAIT_SYNC -> RUN on `sync`. RUN -> RUN on `sync` (reseed). Only reset returns the block to WAIT_SYNC.
- Per keystream bit:
  - fb = s[6] ^ s[3]
  - s <= {s[5:0], fb}
  - out bit i = in bit i ^ fb_i, with i = 0 first.
- One beat consumes `DATA_W` steps. The next-state LFSR value is computed combinationally as a `DATA_W`-step unrolled chain.
- Accept: `in_valid` && `in_ready`. On accept:
  - LFSR advances by `DATA_W` steps.
  - `out_data` is loaded with the descrambled beat.
  - `out_valid` is set.
  - `beat_cnt` increments.
- Stall: with no accept, the LFSR and `beat_cnt` hold. `out_data`/`out_valid` hold while `out_valid` && !`out_ready`.
- Output drain: `out_valid` clears when `out_ready` && !accept.

## Timing
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `in_ready` = 0 (WAIT_SYNC), `beat_cnt` = 0.
  - LFSR = `SEED`.
- Latency: a beat accepted at edge N appears on `out_data`/`out_valid` after edge N. This is one cycle, registered.
- Throughput: one beat per clock while `out_ready` = 1.
- `sync` and accept in the same cycle:
  - The beat is descrambled with the `SEED` keystream, i.e. the first beat of the new frame.
  - The LFSR becomes `SEED` advanced by `DATA_W` steps.
  - `beat_cnt` becomes 1.
- `sync` in WAIT_SYNC: `in_ready` is still 0 that cycle, so acceptance starts the following cycle.
- `sync` without accept: LFSR <= `SEED`, `beat_cnt` <= 0.
- A pending output beat is not discarded by `sync`.
- `out_data` and `out_valid` must not change while `out_valid` && !`out_ready`.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). Any pending output is lost.
- LFSR period is 127 bits. Wrap across beat boundaries is continuous, with no realignment.

## Structure
- A shared package `xor_scrambler_pkg` holds:
  - localparams `LFSR_W` = 7, `TAP_HI` = 6, `TAP_LO` = 3, `DEFAULT_SEED` = 7'h7F.
  - The state enum {WAIT_SYNC, RUN}.
  - A function `lfsr_step_n(state, data, n)` returning the next state and the XORed data.
- The scrambler reuses the same package.
- Natural sub-module: `xor_keystream`. It takes the LFSR register, `load`/`advance` controls and the current `DATA_W`-bit keystream, and is shared with the scrambler. The handshake/output register stays in `xor_descrambler`.

## Test plan
- Reset, then drive `in_valid` = 1 with no `sync` -> `in_ready` = 0, `out_valid` = 0, `beat_cnt` = 0 indefinitely.
- `sync` pulse, then beats 8'h00, 8'h00 with `out_ready` = 1 -> `out_data` 8'h70, then 8'h4F, each 1 cycle after accept; `beat_cnt` = 2.
- `sync`, then beats 8'h70, 8'h4F -> `out_data` 8'h00, 8'h00 (round trip).
- `sync`, then one beat accepted, then `out_ready` = 0 for 5 cycles with `in_valid` = 1:
  - `in_ready` = 0 for those 5 cycles; `out_data` is stable.
  - After release, the next beat uses the 2nd keystream byte, e.g. input 8'h00 -> 8'h4F.
- `sync` asserted in the same cycle as accepting 8'h00 mid-stream -> output 8'h70, `beat_cnt` = 1.
- `sync`, then 127 beats of 8'h00 (1016 bits = 8 periods), then `sync`, then 8'h00 -> output 8'h70 both at the start and after the re-sync. Check that `beat_cnt` wraps 16'hFFFF -> 0 in a long run.

Source files
------------

// File: rtl/xor_scrambler_pkg.sv
// Shared definitions for the additive scrambler / descrambler pair
// built on the 802.11 LFSR (x^7 + x^4 + 1).
package xor_scrambler_pkg;

    localparam int              LFSR_W       = 7;
    localparam int              TAP_HI       = 6;
    localparam int              TAP_LO       = 3;
    localparam logic [6:0]      DEFAULT_SEED = 7'h7F;
    // Widest beat the helper function below can process in one call.
    localparam int              MAX_DATA_W   = 64;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } sync_state_t;

    typedef struct packed {
        logic [LFSR_W-1:0]     state;
        logic [MAX_DATA_W-1:0] data;
    } lfsr_step_t;

    // Advance the LFSR n steps, XORing keystream bit i into data bit i
    // (LSB first). Returns the new LFSR state and the XORed data.
    function automatic lfsr_step_t lfsr_step_n(
        input logic [LFSR_W-1:0]     state,
        input logic [MAX_DATA_W-1:0] data,
        input int                    n
    );
        lfsr_step_t res;
        logic       fb;
        res.state = state;
        res.data  = data;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < n) begin
                fb          = res.state[TAP_HI] ^ res.state[TAP_LO];
                res.data[i] = res.data[i] ^ fb;
                res.state   = {res.state[LFSR_W-2:0], fb};
            end
        end
        return res;
    endfunction

    // A zero seed would lock the LFSR at zero; substitute the default.
    function automatic logic [LFSR_W-1:0] legal_seed(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/xor_keystream.sv
// LFSR keystream generator shared by the scrambler and descrambler.
// Presents the DATA_W-bit keystream for the current beat; when load is
// high the keystream is taken from the seed so a beat accepted in the
// same cycle as a reload becomes the first beat of the new frame.
module xor_keystream
    import xor_scrambler_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] keystream
);

    localparam logic [LFSR_W-1:0] LOAD_VALUE = legal_seed(SEED);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] base_state;
    logic [LFSR_W-1:0] chain_state;

    assign base_state = load ? LOAD_VALUE : lfsr_reg;

    // Unrolled DATA_W-step LFSR chain: keystream bits and the end state.
    always_comb begin
        keystream   = '0;
        chain_state = base_state;
        for (int i = 0; i < DATA_W; i++) begin
            keystream[i] = chain_state[TAP_HI] ^ chain_state[TAP_LO];
            chain_state  = {chain_state[LFSR_W-2:0], keystream[i]};
        end
    end

    // Advance wins over load: a reload with a beat consumes the seed's keystream.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (advance) begin
            lfsr_next = chain_state;
        end else if (load) begin
            lfsr_next = LOAD_VALUE;
        end
    end

    // LFSR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LOAD_VALUE;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

endmodule

// File: rtl/xor_descrambler.sv
// Byte-stream additive descrambler: XORs each accepted beat with the LFSR
// keystream and presents it one cycle later on a registered valid/ready port.
module xor_descrambler
    import xor_scrambler_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       beat_cnt
);

    sync_state_t       state_reg;
    sync_state_t       state_next;
    logic              accept;
    logic [DATA_W-1:0] keystream;
    logic [DATA_W-1:0] descrambled;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic [15:0]       beat_cnt_reg;

    xor_keystream #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_keystream (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sync),
        .advance   (accept),
        .keystream (keystream)
    );

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_xor
            assign descrambled[gi] = in_data[gi] ^ keystream[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake: only a sync leaves WAIT_SYNC; ready needs a free output slot.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        if (sync) begin
            state_next = RUN;
        end
        if (state_reg == RUN) begin
            in_ready = !out_valid_reg || out_ready;
        end
    end

    assign accept = in_valid && in_ready;

    // Output register: load on accept, drain when taken, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_data_reg  <= descrambled;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Beat counter: restarts on sync, a beat taken with sync is beat 1 of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            beat_cnt_reg <= sync ? 16'd1 : beat_cnt_reg + 16'd1;
        end else if (sync) begin
            beat_cnt_reg <= '0;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_xor_descrambler.sv
// Self-checking bench for xor_descrambler: directed cases plus randomized
// traffic against a keystream-position reference model.
module tb_xor_descrambler;

    localparam int DATA_W = 8;
    localparam int PERIOD = 127;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sync;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       beat_cnt;

    always #5 clk = ~clk;

    xor_descrambler #(
        .DATA_W (DATA_W),
        .SEED   (7'h7F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit verbose = 1'b1;

    // One full period of keystream bits starting from the seed.
    logic ks_bits [0:PERIOD-1];

    // Reference model: running flag, bit position in the period, count, output slot.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_cnt;
    logic        m_ov;
    logic [7:0]  m_od;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ks_byte(input int p);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ks_bits[(p + i) % PERIOD];
        return r;
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_cnt = '0;
        m_ov  = 1'b0;
        m_od  = '0;
    endtask

    // One clock: drive at negedge, check ready, update model, check outputs after posedge.
    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic r);
        logic exp_rdy;
        logic acc;
        int   b;
        @(negedge clk);
        sync = s; in_valid = v; in_data = d; out_ready = r;
        #1;
        exp_rdy = m_run && (!m_ov || r);
        expect_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        if (acc) begin
            b     = s ? 0 : m_pos;
            m_od  = d ^ ks_byte(b);
            m_pos = (b + 8) % PERIOD;
            m_cnt = s ? 16'd1 : m_cnt + 16'd1;
            m_ov  = 1'b1;
        end else begin
            if (s) begin
                m_pos = 0;
                m_cnt = '0;
            end
            if (r) m_ov = 1'b0;
        end
        if (s) m_run = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        expect_eq("out_data", {24'd0, out_data}, {24'd0, m_od});
        expect_eq("beat_cnt", {16'd0, beat_cnt}, {16'd0, m_cnt});
        if (acc && verbose)
            $display("beat sync=%0b in=%02h out=%02h cnt=%0d", s, d, out_data, beat_cnt);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sync = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        model_reset();
        expect_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        expect_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        expect_eq("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
        expect_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] held;

    initial begin
        logic [6:0] s;
        logic       fb;
        s = 7'h7F;
        for (int i = 0; i < PERIOD; i++) begin
            fb          = s[6] ^ s[3];
            ks_bits[i]  = fb;
            s           = {s[5:0], fb};
        end
        model_reset();

        rst_n = 1'b0; sync = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        expect_eq("reset_out_data", {24'd0, out_data}, 32'd0);
        expect_eq("reset_beat_cnt", {16'd0, beat_cnt}, 32'd0);
        expect_eq("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No sync: nothing is accepted.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(i), 1'b1);

        // Sync in WAIT_SYNC is not an accept; then two zero beats.
        step(1'b1, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        expect_eq("first_byte", {24'd0, out_data}, 32'h70);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        expect_eq("second_byte", {24'd0, out_data}, 32'h4F);
        expect_eq("two_beats", {16'd0, beat_cnt}, 32'd2);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Round trip.
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h70, 1'b1);
        expect_eq("rt_byte0", {24'd0, out_data}, 32'h00);
        step(1'b0, 1'b1, 8'h4F, 1'b1);
        expect_eq("rt_byte1", {24'd0, out_data}, 32'h00);

        // Backpressure: output held for 5 cycles, then next keystream byte.
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'hAA, 1'b1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            expect_eq("stall_hold", {24'd0, out_data}, {24'd0, held});
        end
        step(1'b0, 1'b1, 8'h00, 1'b1);
        expect_eq("after_stall", {24'd0, out_data}, 32'h4F);

        // Sync coinciding with an accept mid-stream.
        step(1'b0, 1'b1, 8'h12, 1'b1);
        step(1'b1, 1'b1, 8'h00, 1'b1);
        expect_eq("sync_acc_data", {24'd0, out_data}, 32'h70);
        expect_eq("sync_acc_cnt", {16'd0, beat_cnt}, 32'd1);

        // 127 zero beats span 8 full periods, then re-sync.
        step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 127; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b1);
            if (i == 0) expect_eq("long_first", {24'd0, out_data}, 32'h70);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        expect_eq("resync_first", {24'd0, out_data}, 32'h70);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 3) != 0));

        // Mid-stream reset drops pending output and returns to WAIT_SYNC.
        step(1'b0, 1'b1, 8'h33, 1'b0);
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        expect_eq("post_reset_first", {24'd0, out_data}, 32'h70);

        // Counter wrap.
        verbose = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 65535; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);
        expect_eq("wrap_ffff", {16'd0, beat_cnt}, 32'h0000FFFF);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        expect_eq("wrap_zero", {16'd0, beat_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
